disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
// Time-multiplexed scan controller for a bank of NDIG common-anode 7-segment digits.
// It sits between the keypad scanner and the single shared hex-to-7-segment decoder.
// Key codes arrive on a valid/ready port and are shifted into a digit buffer.
// The buffer is scanned one digit at a time onto one decoder, with a blanking gap
// between digits to suppress ghosting.
// PARAMETERS
// NDIG         4      number of digits scanned (>=2)
// REFRESH_DIV  50000  clk cycles per digit slot, gap included (> BLANK_CYCLES)
// BLANK_CYCLES 2      cycles at the start of each slot with all digits off (>=1)
// PORTS
// clk        in   1                  system clock, all logic on rising edge
// reset      in   1                  synchronous, active-high
// key_valid  in   1                  key_code valid
// key_code   in   4                  hex code 1..F; 0 is stored and renders blank
// key_ready  out  1                  key accepted when key_valid & key_ready at clk edge
// clr        in   1                  synchronous clear of digit buffer and entry count
// digit_code out  4                  code to shared decoder; decoder renders 0 as blank
// digit_sel  out  NDIG               active-low digit enables, at most one bit low
// digit_idx  out  $clog2(NDIG)       index of digit currently in its slot
// full       out  1                  NDIG digits entered since reset/clr
// ovf        out  1                  one-cycle pulse: a key was accepted while full
// BEHAVIOUR
// Reset (takes effect at the clk edge with reset high):
// - state=GAP, cnt=0, idx=0, buf[*]=0, count=0.
// - digit_sel=all 1, digit_code=0, full=0, ovf=0.
// - key_ready=0 while reset is high.
// Slot counter cnt runs 0..REFRESH_DIV-1.
// - At cnt==REFRESH_DIV-1: cnt<=0 and idx<=(idx==NDIG-1)?0:idx+1.
// FSM, two states:
// - GAP (cnt<BLANK_CYCLES): digit_sel=all 1, digit_code=0. Goes to ON when cnt==BLANK_CYCLES-1.
// - ON: digit_sel[idx]=0 with all other bits 1, digit_code=buf[idx]. Goes to GAP when cnt==REFRESH_DIV-1.
// Outputs are decoded only from registers (state, idx, buf); no input reaches them combinationally.
// key_ready = (state==GAP) & ~clr & ~reset.
// - The buffer never changes while a digit is lit.
// Key accept (key_valid & key_ready):
// - Shift left: buf[0]<=key_code, buf[i]<=buf[i-1], old buf[NDIG-1] dropped. Digit 0 is rightmost.
// - count saturates at NDIG; full=(count==NDIG).
// - Accept while full: ovf=1 for exactly the next cycle, then 0.
// key_valid held during ON:
// - Not accepted; held until the next GAP.
// - Exactly one accept per GAP cycle if held across a multi-cycle GAP, so the source must drop valid after ready.
// clr:
// - Next edge: buf[*]<=0, count<=0, ovf<=0.
// - Has priority over a key in the same cycle (that key is not accepted).
// - Does not disturb cnt/idx/state.
// Reset mid-slot: scan restarts at digit 0 in GAP; buffer contents are lost.
// The buffer is accessed only through the shift and clear operations above; there is no random write.
// TESTING
// Params for bench: NDIG=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Cycle numbers count from the first edge after reset deasserts.
// 1 Reset:
//   - After reset: digit_sel=1111, digit_code=0, full=0, ovf=0, key_ready=0 while reset=1.
//   - key_ready=1 in the first cycle after release.
// 2 Scan cadence with empty buffer:
//   - cycles 0-1: sel=1111
//   - cycles 2-7: sel=1110, idx=0
//   - cycles 8-9: sel=1111
//   - cycles 10-15: sel=1101
//   - cycle 34: sel=1110 again (idx wrapped 3->0)
// 3 Entry 1,2,3, each presented during GAP:
//   - ON slots show: idx0=3, idx1=2, idx2=1, idx3=0.
//   - key_valid raised at cycle 4 (ON): ready=0, accepted at cycle 8 (GAP).
// 4 Overflow, keys A,B,C,D,E:
//   - full=1 after D.
//   - ovf=1 for one cycle after E.
//   - buf = {B,C,D,E} (idx3..idx0); A dropped.
// 5 clr with key_valid=1, key_code=7 in the same GAP cycle:
//   - buf all 0, full=0, 7 not stored, key_ready=0 that cycle.
// 6 Reset asserted at cycle 5 (ON, idx0) with buf={1,2,3,4}:
//   - Next cycle: sel=1111, idx=0, buf all 0, and the cadence of scenario 2 restarts.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Key-entry handshake between the keypad scanner (master) and the display scan controller (slave).
// A key transfers on the rising clock edge where key_valid and key_ready are both high.
interface disp_scan_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan of an NDIG-digit shift buffer onto one shared 7-segment decoder,
// with a blanking gap at the start of every digit slot. Keys are only taken during the gap.
module disp_scan_ctrl #(
    parameter int NDIG         = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    localparam int IDX_W = $clog2(NDIG),
    localparam int CNT_W = $clog2(REFRESH_DIV),
    localparam int NUM_W = $clog2(NDIG + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    disp_scan_ctrl_if.slave     key_if,
    input  logic                i_clr,
    output logic [3:0]          o_digit_code,
    output logic [NDIG-1:0]     o_digit_sel,
    output logic [IDX_W-1:0]    o_digit_idx,
    output logic                o_full,
    output logic                o_ovf,
    output logic                o_state
);
    typedef enum logic {ST_GAP = 1'b0, ST_ON = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_buf [NDIG];
    logic [NUM_W-1:0] r_count;
    logic             r_ovf;

    logic w_slot_end;
    logic w_ready;
    logic w_accept;
    logic w_full;

    assign w_slot_end = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_full     = (r_count == NUM_W'(NDIG));
    // Ready only in the gap, so the buffer never changes under a lit digit.
    assign w_ready    = (r_state == ST_GAP) & ~i_clr & ~i_reset;
    assign w_accept   = key_if.key_valid & w_ready;

    assign key_if.key_ready = w_ready;
    assign o_digit_idx      = r_idx;
    assign o_full           = w_full;
    assign o_ovf            = r_ovf;
    assign o_state          = r_state;

    always_comb begin
        w_next_state = r_state;
        o_digit_sel  = '1;
        o_digit_code = '0;
        case (r_state)
            ST_GAP: begin
                if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) w_next_state = ST_ON;
            end
            ST_ON: begin
                o_digit_sel[r_idx] = 1'b0;
                o_digit_code       = r_buf[r_idx];
                if (w_slot_end) w_next_state = ST_GAP;
            end
            default: w_next_state = ST_GAP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < NDIG; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (i_clr) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
                for (int i = 0; i < NDIG; i++) r_buf[i] <= '0;
            end else begin
                r_ovf <= w_accept & w_full;
                if (w_accept) begin
                    // Digit 0 is rightmost; the oldest digit falls off the left end.
                    r_buf[0] <= key_if.key_code;
                    for (int i = 1; i < NDIG; i++) r_buf[i] <= r_buf[i-1];
                    if (!w_full) r_count <= r_count + NUM_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (NDIG=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Expected output snapshots are queued with the cycle they apply to; a negedge monitor checks them.
module tb_disp_scan_ctrl;
    localparam logic [12:0] M_SEL  = 13'h000F;
    localparam logic [12:0] M_CODE = 13'h00F0;
    localparam logic [12:0] M_IDX  = 13'h0300;
    localparam logic [12:0] M_FULL = 13'h0400;
    localparam logic [12:0] M_OVF  = 13'h0800;
    localparam logic [12:0] M_RDY  = 13'h1000;
    localparam logic [12:0] M_DISP = M_SEL | M_CODE | M_IDX | M_OVF;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [3:0] digit_code;
    logic [3:0] digit_sel;
    logic [1:0] digit_idx;
    logic       full;
    logic       ovf;
    logic       state;

    int cyc  = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;

    // {cycle[57:26], mask[25:13], value[12:0]}; value = {rdy, ovf, full, idx, code, sel}
    logic [57:0] exp_q [$];
    string       name_q [$];

    disp_scan_ctrl_if kif ();

    disp_scan_ctrl #(.NDIG(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .key_if       (kif),
        .i_clr        (clr),
        .o_digit_code (digit_code),
        .o_digit_sel  (digit_sel),
        .o_digit_idx  (digit_idx),
        .o_full       (full),
        .o_ovf        (ovf),
        .o_state      (state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic go(input int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input int rel, input logic [3:0] code);
        go(rel);
        kif.key_valid = 1'b1;
        kif.key_code  = code;
        go(rel + 1);
        kif.key_valid = 1'b0;
    endtask

    task automatic chk(input int rel, input logic [12:0] m, input logic rdy, input logic ov,
                       input logic fu, input logic [1:0] idx, input logic [3:0] code,
                       input logic [3:0] sel, input string name);
        logic [31:0] c;
        c = 32'(base + rel);
        exp_q.push_back({c, m, rdy, ov, fu, idx, code, sel});
        name_q.push_back(name);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [57:0] e;
        logic [12:0] act;
        string       nm;
        act = {kif.key_ready, ovf, full, digit_idx, digit_code, digit_sel};
        while (exp_q.size() > 0 && int'(exp_q[0][57:26]) <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (int'(e[57:26]) < cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d reached late at cycle %0d", nm, e[57:26], cyc);
            end else if ((act & e[25:13]) != (e[12:0] & e[25:13])) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h expected %h (mask %h)",
                         nm, cyc, act & e[25:13], e[12:0] & e[25:13], e[25:13]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;

        // Reset state
        @(posedge clk);
        #1;
        base = cyc;
        chk(0, M_DISP | M_FULL | M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'b1111, "reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;

        // Scan cadence with empty buffer
        chk(0,  M_RDY | M_SEL | M_FULL | M_OVF, 1, 0, 0, 2'd0, 4'h0, 4'b1111, "ready_after_release");
        chk(1,  M_SEL | M_IDX, 0, 0, 0, 2'd0, 4'h0, 4'b1111, "gap_c1");
        chk(2,  M_DISP, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "on0_c2");
        chk(7,  M_DISP | M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "on0_c7");
        chk(8,  M_SEL | M_IDX | M_RDY, 1, 0, 0, 2'd1, 4'h0, 4'b1111, "gap1_c8");
        chk(9,  M_SEL, 0, 0, 0, 2'd0, 4'h0, 4'b1111, "gap1_c9");
        chk(10, M_DISP, 0, 0, 0, 2'd1, 4'h0, 4'b1101, "on1_c10");
        chk(15, M_DISP, 0, 0, 0, 2'd1, 4'h0, 4'b1101, "on1_c15");
        chk(16, M_SEL, 0, 0, 0, 2'd0, 4'h0, 4'b1111, "gap2_c16");
        chk(18, M_DISP, 0, 0, 0, 2'd2, 4'h0, 4'b1011, "on2_c18");
        chk(26, M_DISP, 0, 0, 0, 2'd3, 4'h0, 4'b0111, "on3_c26");
        chk(34, M_DISP, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "wrap_c34");

        // Entry 1,2,3; key 3 raised during ON and held until the next gap
        go(48);
        chk(48, M_RDY, 1, 0, 0, 2'd0, 4'h0, 4'h0, "ready_gap48");
        chk(60, M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'h0, "held_on_not_ready60");
        chk(63, M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'h0, "held_on_not_ready63");
        chk(64, M_RDY, 1, 0, 0, 2'd0, 4'h0, 4'h0, "held_ready_gap64");
        chk(74, M_DISP | M_FULL, 0, 0, 0, 2'd1, 4'h2, 4'b1101, "entry_idx1");
        chk(82, M_DISP | M_FULL, 0, 0, 0, 2'd2, 4'h1, 4'b1011, "entry_idx2");
        chk(90, M_DISP | M_FULL, 0, 0, 0, 2'd3, 4'h0, 4'b0111, "entry_idx3");
        chk(98, M_DISP | M_FULL, 0, 0, 0, 2'd0, 4'h3, 4'b1110, "entry_idx0");
        key(48, 4'h1);
        key(56, 4'h2);
        go(60);
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h3;
        go(65);
        kif.key_valid = 1'b0;

        // Clear, then overflow with A..E
        go(104);
        chk(104, M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'h0, "clr_blocks_ready");
        chk(105, M_RDY | M_FULL, 1, 0, 0, 2'd0, 4'h0, 4'h0, "after_clr");
        chk(128, M_FULL, 0, 0, 0, 2'd0, 4'h0, 4'h0, "not_full_before_d");
        chk(129, M_FULL | M_OVF, 0, 0, 1, 2'd0, 4'h0, 4'h0, "full_after_d");
        chk(136, M_OVF, 0, 0, 0, 2'd0, 4'h0, 4'h0, "ovf_before_e");
        chk(137, M_OVF | M_FULL, 0, 1, 1, 2'd0, 4'h0, 4'h0, "ovf_pulse");
        chk(138, M_OVF, 0, 0, 0, 2'd0, 4'h0, 4'h0, "ovf_cleared");
        chk(146, M_DISP | M_FULL, 0, 0, 1, 2'd2, 4'hC, 4'b1011, "ovf_idx2");
        chk(154, M_DISP | M_FULL, 0, 0, 1, 2'd3, 4'hB, 4'b0111, "ovf_idx3");
        chk(162, M_DISP | M_FULL, 0, 0, 1, 2'd0, 4'hE, 4'b1110, "ovf_idx0");
        chk(170, M_DISP | M_FULL, 0, 0, 1, 2'd1, 4'hD, 4'b1101, "ovf_idx1");
        clr = 1'b1;
        go(105);
        clr = 1'b0;
        key(105, 4'hA);
        key(112, 4'hB);
        key(120, 4'hC);
        key(128, 4'hD);
        key(136, 4'hE);

        // clr wins over a key in the same gap cycle
        go(176);
        chk(176, M_RDY, 0, 0, 0, 2'd0, 4'h0, 4'h0, "clr_key_not_ready");
        chk(177, M_FULL | M_OVF, 0, 0, 0, 2'd0, 4'h0, 4'h0, "clr_full_cleared");
        chk(178, M_DISP, 0, 0, 0, 2'd2, 4'h0, 4'b1011, "clr_idx2");
        chk(186, M_DISP, 0, 0, 0, 2'd3, 4'h0, 4'b0111, "clr_idx3");
        chk(194, M_DISP, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "clr_idx0_no7");
        chk(202, M_DISP, 0, 0, 0, 2'd1, 4'h0, 4'b1101, "clr_idx1");
        clr = 1'b1;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h7;
        go(177);
        clr = 1'b0;
        kif.key_valid = 1'b0;

        // Load 1,2,3,4 (two keys per two-cycle gap), then reset mid-slot
        go(208);
        chk(218, M_DISP | M_FULL, 0, 0, 1, 2'd3, 4'h1, 4'b0111, "load_idx3");
        chk(226, M_DISP | M_FULL, 0, 0, 1, 2'd0, 4'h4, 4'b1110, "load_idx0");
        chk(229, M_RDY | M_SEL, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "reset_cycle");
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h1;
        go(209);
        kif.key_code  = 4'h2;
        go(210);
        kif.key_valid = 1'b0;
        key(216, 4'h3);
        key(217, 4'h4);
        go(229);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        chk(0,  M_DISP | M_FULL | M_RDY, 1, 0, 0, 2'd0, 4'h0, 4'b1111, "rst_mid_c0");
        chk(1,  M_SEL, 0, 0, 0, 2'd0, 4'h0, 4'b1111, "rst_mid_c1");
        chk(2,  M_DISP, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "rst_mid_idx0");
        chk(10, M_DISP, 0, 0, 0, 2'd1, 4'h0, 4'b1101, "rst_mid_idx1");
        chk(18, M_DISP, 0, 0, 0, 2'd2, 4'h0, 4'b1011, "rst_mid_idx2");
        chk(26, M_DISP, 0, 0, 0, 2'd3, 4'h0, 4'b0111, "rst_mid_idx3");
        chk(34, M_DISP, 0, 0, 0, 2'd0, 4'h0, 4'b1110, "rst_mid_wrap");
        go(40);

        // ---------------- final report ----------------
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        while (exp_q.size() > 0) begin
            logic [57:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            errors++;
            $display("FAIL %s: expected at cycle %0d but never checked (now %0d)", nm, e[57:26], cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
